// File: rtl/usi_tx_seq.sv
// usi_tx_seq: sequencer that owns the usitx transmitter.
// Loads pattern bytes from the host into the usitx state memory, then on
// host_go runs the pattern host_repeat+1 times with a 2-cycle re-arm gap.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   host_wr_valid/data/ready  pattern byte write channel (IDLE only)
//   host_clr, host_go         write-pointer clear / start pulses
//   host_repeat               extra runs after the first
//   host_abort                immediate stop pulse
//   busy, host_done           status: not-IDLE level, completion pulse
//   err, aborted              sticky flags
//   tx_prog_en/addr/wr/data   usitx state-programming port
//   tx_num_states, tx_run     usitx run control
//   tx_done                   usitx run completion level
//   rx_arm                    receiver arm pulse (only with USI_TX_SEQ_RX_ARM_EN)
//
// Optional feature macro: USI_TX_SEQ_RX_ARM_EN
module usi_tx_seq #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned REP_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_wr_valid,
  input  logic [7:0]       host_wr_data,
  output logic             host_wr_ready,
  input  logic             host_clr,
  input  logic             host_go,
  input  logic [REP_W-1:0] host_repeat,
  input  logic             host_abort,
  output logic             busy,
  output logic             host_done,
  output logic             err,
  output logic             aborted,
  output logic             tx_prog_en,
  output logic [15:0]      tx_prog_addr,
  output logic             tx_prog_wr,
  output logic [7:0]       tx_prog_data,
  output logic [16:0]      tx_num_states,
  output logic             tx_run,
  input  logic             tx_done
`ifdef USI_TX_SEQ_RX_ARM_EN
  ,
  output logic             rx_arm
`endif
);

  localparam int unsigned PTR_W = 17;
  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_RUN    = 3'd2,
    S_REARM  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               rearm_q, rearm_d;
  logic               done_q;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               host_done_q, host_done_d;
  logic               err_q, err_d;
  logic               aborted_q, aborted_d;
  logic               prog_en_q, prog_en_d;
  logic [15:0]        prog_addr_q, prog_addr_d;
  logic               prog_wr_q, prog_wr_d;
  logic [7:0]         prog_data_q, prog_data_d;
  logic [PTR_W-1:0]   num_states_q, num_states_d;
  logic               run_q, run_d;
  logic               done_edge;
`ifdef USI_TX_SEQ_RX_ARM_EN
  logic               rx_arm_q, rx_arm_d;
`endif

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rep_cnt_q    <= '0;
      rearm_q      <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      host_done_q  <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      prog_en_q    <= 1'b1;
      prog_addr_q  <= '0;
      prog_wr_q    <= 1'b0;
      prog_data_q  <= '0;
      num_states_q <= '0;
      run_q        <= 1'b0;
`ifdef USI_TX_SEQ_RX_ARM_EN
      rx_arm_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rep_cnt_q    <= rep_cnt_d;
      rearm_q      <= rearm_d;
      done_q       <= tx_done;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      host_done_q  <= host_done_d;
      err_q        <= err_d;
      aborted_q    <= aborted_d;
      prog_en_q    <= prog_en_d;
      prog_addr_q  <= prog_addr_d;
      prog_wr_q    <= prog_wr_d;
      prog_data_q  <= prog_data_d;
      num_states_q <= num_states_d;
      run_q        <= run_d;
`ifdef USI_TX_SEQ_RX_ARM_EN
      rx_arm_q     <= rx_arm_d;
`endif
    end
  end

  // Next state and next output values
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rep_cnt_d    = rep_cnt_q;
    rearm_d      = rearm_q;
    err_d        = err_q;
    aborted_d    = aborted_q;
    prog_addr_d  = prog_addr_q;
    prog_wr_d    = 1'b0;
    prog_data_d  = prog_data_q;
    num_states_d = num_states_q;
    done_edge    = tx_done & ~done_q;

    case (state_q)
      S_IDLE: begin
        // go beats clr and a same-cycle write; clr beats a write
        if (host_go) begin
          if (wr_ptr_q == '0) begin
            err_d = 1'b1;
          end else begin
            rep_cnt_d    = host_repeat;
            num_states_d = wr_ptr_q;
            err_d        = 1'b0;
            aborted_d    = 1'b0;
            state_d      = S_SETUP;
          end
        end else if (host_clr) begin
          wr_ptr_d  = '0;
          err_d     = 1'b0;
          aborted_d = 1'b0;
        end else if (host_wr_valid && ready_q) begin
          prog_wr_d   = 1'b1;
          prog_addr_d = wr_ptr_q[15:0];
          prog_data_d = host_wr_data;
          wr_ptr_d    = wr_ptr_q + PTR_W'(1);
        end
      end
      S_SETUP: begin
        if (host_abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // abort outranks a simultaneous completion edge
        if (host_abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (done_edge) begin
          if (rep_cnt_q == '0) begin
            state_d = S_FINISH;
          end else begin
            rep_cnt_d = rep_cnt_q - REP_W'(1);
            rearm_d   = 1'b0;
            state_d   = S_REARM;
          end
        end
      end
      S_REARM: begin
        if (host_abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (rearm_q) begin
          state_d = S_RUN;
        end else begin
          rearm_d = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it
    ready_d     = (state_d == S_IDLE) && (wr_ptr_d < DEPTH);
    busy_d      = (state_d != S_IDLE);
    prog_en_d   = (state_d == S_IDLE);
    run_d       = (state_d == S_RUN);
    host_done_d = (state_d == S_FINISH);
`ifdef USI_TX_SEQ_RX_ARM_EN
    rx_arm_d    = (state_d == S_RUN) && (state_q != S_RUN);
`endif
  end

  assign host_wr_ready = ready_q;
  assign busy          = busy_q;
  assign host_done     = host_done_q;
  assign err           = err_q;
  assign aborted       = aborted_q;
  assign tx_prog_en    = prog_en_q;
  assign tx_prog_addr  = prog_addr_q;
  assign tx_prog_wr    = prog_wr_q;
  assign tx_prog_data  = prog_data_q;
  assign tx_num_states = num_states_q;
  assign tx_run        = run_q;
`ifdef USI_TX_SEQ_RX_ARM_EN
  assign rx_arm        = rx_arm_q;
`endif

endmodule
